serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
Bit-serial adder/subtractor that turns two parallel operands into an LSB-first bit stream and accumulates the result one bit per clock. Each bit is formed by two half-adder cells (XOR for sum, NAND-pair for carry) and a carry flip-flop. It is the sequential counterpart of the combinational half adder used in the simulation tutorials, and serves as the worked example for sequential simulation: probes on the carry flop, bit counter and state show the carry chain unrolled in time. A start/busy/done handshake connects it to a parallel host (switches, registers or a test module).

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request a new operation; sampled on rising clk
sub  input  1  0 = A+B, 1 = A-B; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; result/cout/ovf valid
result  output  WIDTH  sum or difference, held until next completion
cout  output  1  final carry out (for sub: 1 = no borrow, i.e. A>=B unsigned)
ovf  output  1  two's-complement overflow

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0; shift registers, carry flop and bit counter cleared.
- States:
  - IDLE: wait for a start.
  - RUN: process one bit per cycle.
  - DONE: one-cycle completion state.
- Start acceptance:
  - Start is accepted on a rising edge where start=1 and state is IDLE or DONE.
  - Accept edge actions: opA<=a; opB<=(sub ? ~b : b); carry<=sub; count<=0; state<=RUN.
- RUN, each edge:
  - s = opA[0] ^ opB[0] ^ carry.
  - c = majority(opA[0], opB[0], carry), built as two half adders plus OR.
  - Shift s into the accumulator from the MSB end; shift opA and opB right by 1.
  - carry<=c; count<=count+1.
  - Record the carry into the MSB (the carry value before the last bit) for the overflow calculation.
- Final RUN edge (count=WIDTH-1):
  - result<=final accumulator; cout<=c; ovf<=carry_into_MSB ^ c.
  - state<=DONE.
- Latency: the result is complete WIDTH edges after the accept edge. done is high for exactly the cycle after that edge. busy is high for exactly WIDTH cycles.
- DONE: done=1, busy=0. On the next edge go to IDLE, or straight back to RUN if start=1 (back-to-back operation with no dead cycle).
- start while RUN: ignored; operands, sub and the operation in flight are unaffected.
- Output hold: result, cout and ovf change only on the final RUN edge, or on reset. They hold their values through IDLE and through the next operation's RUN until that operation completes.
- a, b and sub may change freely after the accept edge.
- Wrap-around: arithmetic is modulo 2^WIDTH; cout and ovf report the lost carry and the sign error.
- Reset mid-RUN: the operation is aborted; all outputs go to their reset values; no done pulse.
- Bit counter width: clog2(WIDTH)+1 bits; it must not wrap before WIDTH-1.

Test Plan:
- WIDTH=8, start with a=0x3C, b=0x05, sub=0 -> busy high 8 cycles; done pulses 8 edges after accept; result=0x41, cout=0, ovf=0.
- a=0xFF, b=0x01, sub=0 -> result=0x00, cout=1, ovf=0; a=0x7F, b=0x01, sub=0 -> result=0x80, cout=0, ovf=1.
- sub=1: a=0x05, b=0x07 -> result=0xFE, cout=0 (borrow), ovf=0; a=0x80, b=0x01 -> result=0x7F, cout=1, ovf=1.
- Start accepted with 0x10+0x20; pulse start with a=0xAA 3 cycles later (during RUN) -> ignored, result=0x30; start held high in the done cycle with 0x01+0x01 -> next busy with no idle gap, result=0x02.
- Complete 0x3C+0x05 (result=0x41), then start a new op and assert reset at the 4th RUN cycle -> busy, done, result, cout, ovf all 0 immediately, without waiting for a clock edge; no done pulse afterwards; a fresh op 0x22+0x11 gives 0x33.
- Randomized 200 ops with WIDTH=8 and WIDTH=13 checked against a reference model -> result, cout and ovf match, and done is always exactly WIDTH edges after accept.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: operands shift out LSB-first, one sum bit per clock,
// with a start/busy/done handshake to a parallel host.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opa_q, opb_q, acc_q, result_q;
  logic [CW-1:0]    count_q;
  logic             carry_q, busy_q, done_q, cout_q, ovf_q;

  // Bit cell: two half adders (XOR sum, NAND-pair carry) plus OR.
  logic s1, c1_n, c1, s, c2_n, c2, c;
  assign s1   = opa_q[0] ^ opb_q[0];
  assign c1_n = ~(opa_q[0] & opb_q[0]);
  assign c1   = ~(c1_n & c1_n);
  assign s    = s1 ^ carry_q;
  assign c2_n = ~(s1 & carry_q);
  assign c2   = ~(c2_n & c2_n);
  assign c    = c1 | c2;

  logic [WIDTH-1:0] acc_d;
  logic             last;
  assign acc_d = {s, acc_q[WIDTH-1:1]};
  assign last  = (count_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      count_q  <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          acc_q   <= acc_d;
          opa_q   <= opa_q >> 1;
          opb_q   <= opb_q >> 1;
          carry_q <= c;
          count_q <= count_q + 1'b1;
          // carry_q here is the carry into the MSB, so overflow is its XOR with carry out
          if (last) begin
            result_q <= acc_d;
            cout_q   <= c;
            ovf_q    <= carry_q ^ c;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: begin
          done_q <= 1'b0;
          if (start) begin
            opa_q   <= a;
            opb_q   <= sub ? ~b : b;
            carry_q <= sub;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed vectors, handshake corner cases and random
// operations at WIDTH=8 and WIDTH=13 against an arithmetic reference model.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        reset;
  logic        start8, start13, sub_s;
  logic [31:0] a_s, b_s;
  logic        busy8, done8, cout8, ovf8;
  logic        busy13, done13, cout13, ovf13;
  logic [7:0]  res8;
  logic [12:0] res13;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub_s),
    .a(a_s[7:0]), .b(b_s[7:0]), .busy(busy8), .done(done8),
    .result(res8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(13)) dut13 (
    .clk(clk), .reset(reset), .start(start13), .sub(sub_s),
    .a(a_s[12:0]), .b(b_s[12:0]), .busy(busy13), .done(done13),
    .result(res13), .cout(cout13), .ovf(ovf13)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : busy13;
  endfunction
  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : done13;
  endfunction
  function automatic logic [31:0] get_res(input int w);
    return (w == 8) ? {24'd0, res8} : {19'd0, res13};
  endfunction
  function automatic logic get_cout(input int w);
    return (w == 8) ? cout8 : cout13;
  endfunction
  function automatic logic get_ovf(input int w);
    return (w == 8) ? ovf8 : ovf13;
  endfunction

  // Reference: plain unsigned/signed arithmetic on the operand values.
  task automatic model(input int w, input logic [31:0] av, input logic [31:0] bv, input logic sv,
                       output logic [31:0] r, output logic co, output logic ov);
    longint mod, ua, ub, sa, sb, s;
    mod = longint'(1) << w;
    ua  = longint'(av) % mod;
    ub  = longint'(bv) % mod;
    sa  = (ua >= mod / 2) ? ua - mod : ua;
    sb  = (ub >= mod / 2) ? ub - mod : ub;
    if (sv) begin
      r  = 32'((ua - ub + mod) % mod);
      co = (ua >= ub);
      s  = sa - sb;
    end else begin
      r  = 32'((ua + ub) % mod);
      co = (ua + ub >= mod);
      s  = sa + sb;
    end
    ov = (s >= mod / 2) || (s < -(mod / 2));
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 8) start8 = v; else start13 = v;
  endtask

  // Returns one negedge after the accept edge; inputs are scrambled afterwards.
  task automatic start_op(input int w, input logic [31:0] av, input logic [31:0] bv, input logic sv);
    @(negedge clk);
    a_s = av; b_s = bv; sub_s = sv;
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
    a_s = $urandom; b_s = $urandom; sub_s = 1'($urandom_range(0, 1));
  endtask

  // Counts edges until done (relative to now) and busy cycles; flags result changes before done.
  task automatic wait_done(input int w, output int edges, output int busyc, output bit held);
    logic [31:0] prev;
    prev  = get_res(w);
    held  = 1'b1;
    edges = -1;
    busyc = get_busy(w) ? 1 : 0;
    for (int k = 1; k <= w + 10; k++) begin
      @(negedge clk);
      if (get_done(w)) begin
        edges = k;
        break;
      end
      if (get_busy(w)) busyc++;
      if (get_res(w) !== prev) held = 1'b0;
    end
  endtask

  task automatic check_outputs(input string name, input int w, input logic [31:0] r,
                               input logic co, input logic ov);
    check({name, ".result"}, get_res(w), r);
    check({name, ".cout"}, 32'(get_cout(w)), 32'(co));
    check({name, ".ovf"}, 32'(get_ovf(w)), 32'(ov));
  endtask

  task automatic run_checked(input string name, input int w, input logic [31:0] av,
                             input logic [31:0] bv, input logic sv,
                             input logic [31:0] r, input logic co, input logic ov);
    int  edges, busyc;
    bit  held;
    start_op(w, av, bv, sv);
    wait_done(w, edges, busyc, held);
    check({name, ".latency"}, 32'(edges), 32'(w));
    check({name, ".busy_cycles"}, 32'(busyc), 32'(w));
    check({name, ".hold"}, 32'(held), 32'd1);
    check({name, ".busy_in_done"}, 32'(get_busy(w)), 32'd0);
    check_outputs(name, w, r, co, ov);
  endtask

  typedef struct {
    string       name;
    logic [31:0] a, b;
    logic        sub;
    logic [31:0] res;
    logic        co, ov;
  } vec_t;

  initial begin
    vec_t        tv[5];
    int          edges, busyc;
    bit          held;
    logic [31:0] r;
    logic        co, ov;
    bit          seen_done;

    tv[0] = '{"add_3c_05", 32'h3C, 32'h05, 1'b0, 32'h41, 1'b0, 1'b0};
    tv[1] = '{"add_ff_01", 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0};
    tv[2] = '{"add_7f_01", 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1};
    tv[3] = '{"sub_05_07", 32'h05, 32'h07, 1'b1, 32'hFE, 1'b0, 1'b0};
    tv[4] = '{"sub_80_01", 32'h80, 32'h01, 1'b1, 32'h7F, 1'b1, 1'b1};

    reset = 1'b1; start8 = 1'b0; start13 = 1'b0; sub_s = 1'b0; a_s = '0; b_s = '0;
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(busy8), 0);
    check("rst.done", 32'(done8), 0);
    check_outputs("rst8", 8, 32'h0, 1'b0, 1'b0);
    check_outputs("rst13", 13, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_checked(tv[i].name, 8, tv[i].a, tv[i].b, tv[i].sub, tv[i].res, tv[i].co, tv[i].ov);
      @(negedge clk);
      check({tv[i].name, ".done_pulse"}, 32'(done8), 0);
    end

    // start during RUN is ignored
    start_op(8, 32'h10, 32'h20, 1'b0);
    repeat (3) @(negedge clk);
    a_s = 32'hAA; b_s = 32'h00; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done(8, edges, busyc, held);
    check("ignore.latency", 32'(edges), 32'd4);
    check("ignore.result", get_res(8), 32'h30);

    // start held in the done cycle: back-to-back with no idle gap
    a_s = 32'h01; b_s = 32'h01; sub_s = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b.busy", 32'(busy8), 1);
    check("b2b.done", 32'(done8), 0);
    wait_done(8, edges, busyc, held);
    check("b2b.latency", 32'(edges), 32'd8);
    check("b2b.result", get_res(8), 32'h02);

    // reset mid-RUN aborts immediately and produces no done pulse
    run_checked("pre_rst", 8, 32'h3C, 32'h05, 1'b0, 32'h41, 1'b0, 1'b0);
    start_op(8, 32'h33, 32'h44, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst.busy", 32'(busy8), 0);
    check("midrst.done", 32'(done8), 0);
    check_outputs("midrst", 8, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done8 || busy8) seen_done = 1'b1;
    end
    check("midrst.no_done", 32'(seen_done), 0);
    run_checked("post_rst", 8, 32'h22, 32'h11, 1'b0, 32'h33, 1'b0, 1'b0);

    // randomized operations on both widths
    for (int wi = 0; wi < 2; wi++) begin
      int w;
      w = (wi == 0) ? 8 : 13;
      for (int n = 0; n < 200; n++) begin
        logic [31:0] av, bv;
        logic        sv;
        av = $urandom; bv = $urandom; sv = 1'($urandom_range(0, 1));
        case (n % 8)
          0: av = 32'hFFFF_FFFF;
          1: bv = 32'h0;
          2: av = 32'(1) << (w - 1);
          default: ;
        endcase
        model(w, av, bv, sv, r, co, ov);
        run_checked($sformatf("rnd%0d_%0d", w, n), w, av, bv, sv, r, co, ov);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
